load_store_unit: RTL and testbench

//  Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW against a data-memory bus with a req/gnt/rvalid handshake.

---
 rtl/rv32i_opcodes_pkg.sv | 33 +++
 rtl/load_store_unit_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_opcodes_pkg.sv
// Shared RV32I load/store encodings, LSU state type and access legality helpers.
package rv32i_opcodes;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } lsu_state_t;

  // Loads reject 011/110/111; stores only define 000..010.
  function automatic logic ls_is_illegal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return (funct3 > 3'b010);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

  function automatic logic ls_is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Byte-lane select and sign/zero extension of a raw 32-bit read word.
module lsu_load_align
  import rv32i_opcodes::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  mem_size_t   i_funct3,
  output logic [31:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_data_c = i_rdata;
    case (i_funct3)
      LS_B:    o_data_c = {{24{w_byte[7]}}, w_byte};
      LS_BU:   o_data_c = {24'h00_0000, w_byte};
      LS_H:    o_data_c = {{16{w_half[15]}}, w_half};
      LS_HU:   o_data_c = {16'h0000, w_half};
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: req/gnt/rvalid bus master with alignment, legality and timeout checks.
module load_store_unit
  import rv32i_opcodes::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             done,
  output logic [WIDTH-1:0] mem_rd_data,
  output logic             exc_misalign,
  output logic             exc_illegal,
  output logic             bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  if (WIDTH != 32) begin : g_width_chk
    $error("load_store_unit: only WIDTH=32 is supported");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("load_store_unit: TIMEOUT_CYCLES must be >= 1");
  end

  lsu_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_last;

  logic             r_is_store;
  mem_size_t        r_funct3;
  logic [1:0]       r_off;
  logic             r_req_ready, r_mem_req, r_mem_we;
  logic [WIDTH-1:0] r_mem_addr, r_mem_wdata, r_rd_data;
  logic [3:0]       r_mem_be;
  logic             r_done, r_exc_misalign, r_exc_illegal, r_bus_err;

  logic             w_illegal, w_misalign, w_latch, w_load_upd;
  logic             w_done_nxt, w_mis_nxt, w_ill_nxt, w_berr_nxt;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata, w_load_data;

  assign w_illegal  = ls_is_illegal(req_is_store, req_funct3);
  assign w_misalign = ls_is_misaligned(req_funct3, req_addr[1:0]);
  assign w_last     = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Store lane replication and byte enables; loads reuse the same enables.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << req_addr[1:0];
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .i_rdata  (mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data_c (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state plus next values of the registered status pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_load_upd  = 1'b0;
    w_done_nxt  = 1'b0;
    w_mis_nxt   = 1'b0;
    w_ill_nxt   = 1'b0;
    w_berr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_illegal) begin
            w_state_nxt = FAULT;
            w_ill_nxt   = 1'b1;
          end else if (w_misalign) begin
            w_state_nxt = FAULT;
            w_mis_nxt   = 1'b1;
          end else begin
            w_state_nxt = REQ;
            w_cnt_nxt   = '0;
            w_latch     = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = IDLE;
          w_berr_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_load_upd  = !r_is_store;
        end else if (w_last) begin
          w_state_nxt = IDLE;
          w_berr_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      FAULT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready    <= 1'b1;
      r_mem_req      <= 1'b0;
      r_done         <= 1'b0;
      r_exc_misalign <= 1'b0;
      r_exc_illegal  <= 1'b0;
      r_bus_err      <= 1'b0;
      r_rd_data      <= '0;
      r_is_store     <= 1'b0;
      r_funct3       <= LS_B;
      r_off          <= 2'b00;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_be       <= 4'b0000;
      r_mem_wdata    <= '0;
    end else begin
      r_req_ready    <= (w_state_nxt == IDLE);
      r_mem_req      <= (w_state_nxt == REQ);
      r_done         <= w_done_nxt;
      r_exc_misalign <= w_mis_nxt;
      r_exc_illegal  <= w_ill_nxt;
      r_bus_err      <= w_berr_nxt;
      if (w_load_upd) r_rd_data <= w_load_data;
      if (w_latch) begin
        r_is_store  <= req_is_store;
        r_funct3    <= mem_size_t'(req_funct3);
        r_off       <= req_addr[1:0];
        r_mem_we    <= req_is_store;
        r_mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign done         = r_done;
  assign mem_rd_data  = r_rd_data;
  assign exc_misalign = r_exc_misalign;
  assign exc_illegal  = r_exc_illegal;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions queued at issue, compared on output pulses.
module tb_load_store_unit;

  localparam int unsigned TO = 4;
  localparam logic [3:0] EV_DONE = 4'b1000;
  localparam logic [3:0] EV_MIS  = 4'b0100;
  localparam logic [3:0] EV_ILL  = 4'b0010;
  localparam logic [3:0] EV_BERR = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        req_ready, mem_req, mem_we, done, exc_misalign, exc_illegal, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rd_data;
  logic [3:0]  mem_be;

  typedef struct packed {
    logic [3:0]  ev;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .done(done), .mem_rd_data(mem_rd_data), .exc_misalign(exc_misalign),
    .exc_illegal(exc_illegal), .bus_err(bus_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Completion monitor: every status pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (done || exc_misalign || exc_illegal || bus_err)) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_event", {28'h0, done, exc_misalign, exc_illegal, bus_err}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("event", {28'h0, done, exc_misalign, exc_illegal, bus_err}, {28'h0, e.ev});
        check_eq("rd_data", mem_rd_data, e.rd);
      end
    end
  end

  // Drives one access from a negedge; returns on the negedge where its result pulse is visible.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gd, input int rvd,
                           input logic [31:0] rdata);
    logic        ill, mis;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] ewd;
    exp_t        e;
    off = addr[1:0];
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = (f3[1:0] == 2'b01) ? off[0] : (f3[1:0] == 2'b10) ? (off != 2'b00) : 1'b0;
    check_eq("ready_at_issue", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (ill || mis) begin
      e.ev = ill ? EV_ILL : EV_MIS;
      e.rd = last_rd;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("fault_no_req", {31'h0, mem_req}, 32'h0);
      check_eq("fault_exc", {30'h0, exc_misalign, exc_illegal}, {30'h0, mis & ~ill, ill});
      @(negedge clk);
      check_eq("fault_no_req2", {31'h0, mem_req}, 32'h0);
      check_eq("fault_ready", {31'h0, req_ready}, 32'h1);
      return;
    end
    case (f3[1:0])
      2'b00:   begin be = 4'b0001 << off; ewd = {24'h0, wd[7:0]} * 32'h0101_0101; end
      2'b01:   begin be = 4'b0011 << off; ewd = {16'h0, wd[15:0]} * 32'h0001_0001; end
      default: begin be = 4'b1111;        ewd = wd; end
    endcase
    if (!st) last_rd = model_load(f3, off, rdata);
    e.ev = EV_DONE;
    e.rd = last_rd;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= gd; i++) begin
      check_eq("mem_req", {31'h0, mem_req}, 32'h1);
      check_eq("ready_busy", {31'h0, req_ready}, 32'h0);
      check_eq("mem_addr", mem_addr, {addr[31:2], 2'b00});
      check_eq("mem_be", {28'h0, mem_be}, {28'h0, be});
      check_eq("mem_we", {31'h0, mem_we}, {31'h0, st});
      if (st) check_eq("mem_wdata", mem_wdata, ewd);
      if (i == gd) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    for (int i = 0; i <= rvd; i++) begin
      check_eq("req_dropped", {31'h0, mem_req}, 32'h0);
      if (i == rvd) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    check_eq("done_timing", {31'h0, done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_status", {28'h0, done, exc_misalign, exc_illegal, bus_err}, 32'h0);
    check_eq("rst_rd_data", mem_rd_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_0000);
    do_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_0000);
    do_access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 0, 32'hBEEF_1234);
    do_access(1'b1, 3'b001, 32'h0000_0206, 32'h0000_ABCD, 0, 0, 32'h0);
    do_access(1'b1, 3'b000, 32'h0000_0203, 32'h1234_5677, 1, 0, 32'h0);
    do_access(1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 1, 32'h8001_7F00);
    do_access(1'b0, 3'b000, 32'h0000_0101, 32'h0, 0, 0, 32'h0000_7F00);
    do_access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
    do_access(1'b0, 3'b001, 32'h0000_0103, 32'h0, 0, 0, 32'h0);
    do_access(1'b1, 3'b011, 32'h0000_0200, 32'h1, 0, 0, 32'h0);
    do_access(1'b0, 3'b111, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
    do_access(1'b1, 3'b010, 32'h0000_0208, 32'hCAFE_F00D, 0, 0, 32'h0);
    do_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, TO - 1, TO - 1, 32'h1357_9BDF);

    // Response never arrives: bus_err after the timeout, then a late rvalid must be ignored.
    e.ev = EV_BERR; e.rd = last_rd; sb_q.push_back(e);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) break;
    end
    check_eq("timeout_seen", sb_q.size(), 32'h0);
    check_eq("timeout_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    check_eq("late_rvalid_rd", mem_rd_data, last_rd);
    check_eq("late_rvalid_req", {31'h0, mem_req}, 32'h0);

    // Reset while waiting in RESP: bus request gone and ready at once, no completion.
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check_eq("resp_busy", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_mid_rd", mem_rd_data, 32'h0);
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_rd", mem_rd_data, 32'h0);
    do_access(1'b0, 3'b100, 32'h0000_0602, 32'h0, 0, 0, 32'h00A5_0000);

    repeat (2) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
